sdiv_sequencer: RTL and testbench

Signed-division front end that sits directly upstream of the 8-bit unsigned restoring divider core and consumes its result. It accepts two's-complement operands over a valid/ready handshake, screens divide-by-zero, launches the core on operand magnitudes, then sign-corrects the core's quotient and remainder. It presents the signed result and status flags over a valid/ready output. Truncating division: quotient sign = sign(dividend) XOR sign(divisor); remainder sign follows the dividend.

---
 rtl/sdiv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sdiv_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdiv_sequencer.sv
// Signed-division front end for an unsigned restoring divider core: operand screening,
// magnitude launch, sign correction. Define SDIV_SAT_EN to saturate the overflow quotient.
module sdiv_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             core_start,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic [WIDTH-1:0] core_quot,
  input  logic [WIDTH-1:0] core_rem,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             out_tmo,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SDIV_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_n_q, sign_n_d, sign_d_q, sign_d_d;
  logic [WIDTH-1:0] mag_n_q, mag_n_d, mag_d_q, mag_d_d;
  logic [WIDTH-1:0] raw_quot_q, raw_quot_d, raw_rem_q, raw_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic             start_q, start_d, valid_q, valid_d;
  logic             ready_q, ready_d, busy_q, busy_d;
  logic             q_neg;
  logic [WIDTH-1:0] quot_signed;

  assign q_neg       = sign_n_q ^ sign_d_q;
  assign quot_signed = q_neg ? -raw_quot_q : raw_quot_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_n_d   = sign_n_q;
    sign_d_d   = sign_d_q;
    mag_n_d    = mag_n_q;
    mag_d_d    = mag_d_q;
    raw_quot_d = raw_quot_q;
    raw_rem_d  = raw_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    start_d    = 1'b0;
    valid_d    = valid_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          sign_n_d = in_dividend[WIDTH-1];
          sign_d_d = in_divisor[WIDTH-1];
          mag_n_d  = in_dividend[WIDTH-1] ? -in_dividend : in_dividend;
          mag_d_d  = in_divisor[WIDTH-1]  ? -in_divisor  : in_divisor;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          if (in_divisor == '0) begin
            // The core is bypassed entirely; the dividend is returned as the remainder.
            state_d = S_HOLD;
            dbz_d   = 1'b1;
            quot_d  = '0;
            rem_d   = in_dividend;
            valid_d = 1'b1;
          end else begin
            state_d = S_LAUNCH;
            start_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (core_done) begin
          raw_quot_d = core_quot;
          raw_rem_d  = core_rem;
          state_d    = S_FIX;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_FIX: begin
        // Only MIN/-1 yields an unsigned quotient of 2^(W-1) with a positive sign.
        ovf_d = (raw_quot_q == MIN_NEG) && !q_neg;
`ifdef SDIV_SAT_EN
        quot_d = ovf_d ? MAX_POS : quot_signed;
`else
        quot_d = quot_signed;
`endif
        rem_d   = sign_n_q ? -raw_rem_q : raw_rem_q;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sign_n_q   <= 1'b0;
      sign_d_q   <= 1'b0;
      mag_n_q    <= '0;
      mag_d_q    <= '0;
      raw_quot_q <= '0;
      raw_rem_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sign_n_q   <= sign_n_d;
      sign_d_q   <= sign_d_d;
      mag_n_q    <= mag_n_d;
      mag_d_q    <= mag_d_d;
      raw_quot_q <= raw_quot_d;
      raw_rem_q  <= raw_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready      = ready_q;
  assign busy          = busy_q;
  assign core_start    = start_q;
  assign core_dividend = mag_n_q;
  assign core_divisor  = mag_d_q;
  assign out_valid     = valid_q;
  assign out_quot      = quot_q;
  assign out_rem       = rem_q;
  assign out_dbz       = dbz_q;
  assign out_ovf       = ovf_q;
  assign out_tmo       = tmo_q;

endmodule

// File: tb/tb_sdiv_sequencer.sv
// Scoreboard bench for sdiv_sequencer with a behavioural unsigned divider core model.
module tb_sdiv_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_dividend = '0;
  logic [7:0] in_divisor = '0;
  logic       core_start;
  logic [7:0] core_dividend, core_divisor;
  logic [7:0] core_quot = '0;
  logic [7:0] core_rem = '0;
  logic       core_done = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_quot, out_rem;
  logic       out_dbz, out_ovf, out_tmo, busy;

  sdiv_sequencer #(.WIDTH(8), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_quot(core_quot), .core_rem(core_rem), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem),
    .out_dbz(out_dbz), .out_ovf(out_ovf), .out_tmo(out_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef SDIV_SAT_EN
  localparam logic [7:0] OVF_Q = 8'h7F;
`else
  localparam logic [7:0] OVF_Q = 8'h80;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;

  // Core model: not reset, so a launch aborted by rst still produces a late done.
  bit core_en = 1'b1;
  int core_lat = 3;
  int core_cnt = 0;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start && core_en) begin
      core_cnt  <= core_lat;
      core_quot <= (core_divisor == 0) ? 8'h00 : core_dividend / core_divisor;
      core_rem  <= (core_divisor == 0) ? 8'h00 : core_dividend % core_divisor;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_done <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                              input logic dbz, input logic ovf, input logic tmo);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.tmo = tmo;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got quot 0x%0h rem 0x%0h with nothing expected", out_quot, out_rem);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_quot", {24'h0, out_quot}, {24'h0, mon_e.q});
        check("out_rem",  {24'h0, out_rem},  {24'h0, mon_e.r});
        check("out_flags", {29'h0, out_dbz, out_ovf, out_tmo}, {29'h0, mon_e.dbz, mon_e.ovf, mon_e.tmo});
      end
    end
  end

  // Returns #1 after the accepting clock edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int k;
    exp_q.push_back(e);
    @(negedge clk);
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", k);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: in_ready 0, required 1");
    end
  endtask

  logic [7:0] va[8] = '{8'h9C, 8'h64, 8'h9C, 8'h07, 8'hF9, 8'h7F, 8'h80, 8'h80};
  logic [7:0] vb[8] = '{8'h07, 8'hF9, 8'hF9, 8'h64, 8'h64, 8'h80, 8'h80, 8'h01};
  logic [7:0] vq[8] = '{8'hF2, 8'hF2, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80};
  logic [7:0] vr[8] = '{8'hFE, 8'h02, 8'hFE, 8'h07, 8'hF9, 8'h7F, 8'h00, 8'h00};

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_outputs", {out_quot, out_rem, core_dividend, core_divisor}, 0);
    check("rst_flags", {out_dbz, out_ovf, out_tmo}, 0);

    // 100 / 7: start pulse and done-to-valid latency
    send(8'h64, 8'h07, mk(8'h0E, 8'h02, 0, 0, 0));
    check("start_after_accept", core_start, 1);
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
    @(posedge clk);
    #1;
    check("start_one_cycle", core_start, 0);
    check("core_operands", {core_dividend, core_divisor}, {8'h64, 8'h07});
    k = 0;
    while (!core_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("core_done_seen", core_done, 1);
    @(posedge clk);
    #1 check("valid_not_in_fix", out_valid, 0);
    @(posedge clk);
    #1 check("valid_two_after_done", out_valid, 1);

    for (int i = 0; i < 8; i++) send(va[i], vb[i], mk(vq[i], vr[i], 0, 0, 0));

    // divide by zero
    send(8'h05, 8'h00, mk(8'h00, 8'h05, 1, 0, 0));
    check("dbz_valid_lat", out_valid, 1);
    check("dbz_no_start", core_start, 0);
    send(8'h80, 8'h00, mk(8'h00, 8'h80, 1, 0, 0));
    check("dbz_no_start_min", core_start, 0);

    // overflow
    send(8'h80, 8'hFF, mk(OVF_Q, 8'h00, 0, 1, 0));
    check("min_magnitude", {core_dividend, core_divisor}, {8'h80, 8'h01});

    // core never answers
    wait_idle();
    core_en = 1'b0;
    send(8'h09, 8'h03, mk(8'h00, 8'h00, 0, 0, 1));
    repeat (31) @(posedge clk);
    #1 check("tmo_not_early", out_valid, 0);
    @(posedge clk);
    #1 check("tmo_valid", out_valid, 1);
    wait_idle();
    core_en = 1'b1;

    // stalled downstream
    out_ready = 1'b0;
    send(8'h32, 8'h05, mk(8'h0A, 8'h00, 0, 0, 0));
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_stable", {out_valid, in_ready, out_quot, out_rem}, {1'b1, 1'b0, 8'h0A, 8'h00});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;

    // reset during WAIT, then a late done
    wait_idle();
    core_lat = 8;
    send(8'h14, 8'h03, mk(8'h06, 8'h02, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_start", core_start, 0);
    check("abort_core_operands", {core_dividend, core_divisor}, 0);
    exp_q.delete();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check("late_done_ignored", {busy, out_valid, in_ready}, 3'b001);
    end
    core_lat = 3;
    send(8'h14, 8'h03, mk(8'h06, 8'h02, 0, 0, 0));

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

endmodule
